bcd_converter_seq: RTL and testbench
====================================

BCD_CONVERTER_SEQ -- requirements
Module: bcd_converter_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8: width of the binary input; legal range 4 to 32.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits; legal range 1 to 10.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: request a conversion of binary; sampled only in IDLE.
REQ-006 SHALL have port binary  input  BIN_W: unsigned value, captured on the accepting edge only.
REQ-007 SHALL have port busy  output  1: high while a conversion is in progress.
REQ-008 SHALL have port done  output  1: one-cycle pulse marking new bcd/overflow/sig_digits.
REQ-009 SHALL have port bcd  output  4*DIGITS: packed BCD result, digit 0 in bits [3:0], held until next done.
REQ-010 SHALL have port overflow  output  1: result did not fit in DIGITS digits, held with bcd.
REQ-011 SHALL have port sig_digits  output  $clog2(DIGITS+1): count of significant digits in bcd (1 for value 0), held with bcd.

Function
REQ-012 SHALL implement sequential double-dabble in states IDLE and SHIFT, one bit per clock, MSB first.
REQ-013 SHALL, in IDLE with start=1 at an edge: capture binary, clear the working BCD register and carry flag, load bit counter with 0, enter SHIFT.
REQ-014 SHALL, in SHIFT each edge: add 3 to every working digit >=5, then shift left one bit, inserting the next binary MSB.
REQ-015 SHALL OR the bit shifted out of the top working digit into a sticky carry flag on each shift.
REQ-016 SHALL, on the edge performing shift number BIN_W: load bcd, overflow (=carry flag incl. final shift) and sig_digits, assert done for the following cycle, return to IDLE.
REQ-017 SHALL give latency of exactly BIN_W edges from the accepting edge to the edge raising done.
REQ-018 SHALL hold busy=1 in every SHIFT cycle and busy=0 in IDLE, including the done cycle.
REQ-019 SHALL ignore start while busy=1; binary changes during SHIFT have no effect.
REQ-020 SHALL accept a new start during the done cycle (back-to-back interval BIN_W+1 cycles).
REQ-021 SHALL, on overflow, present bcd equal to input value modulo 10^DIGITS.
REQ-022 SHALL compute sig_digits as index of highest nonzero digit plus 1, or 1 if all digits zero.
REQ-023 SHALL keep done low except for the single cycle of REQ-016.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, bcd=0, overflow=0, sig_digits=1, counter and working registers 0, independent of clk.
REQ-025 SHALL, on reset mid-conversion, abort with no done pulse and leave bcd at 0.
REQ-026 SHALL accept start at the first rising edge after rst_n deasserts.

Verification
REQ-027 SHALL cover: BIN_W=8, DIGITS=3, binary=255, start one cycle -> busy 8 cycles, done after 8th edge, bcd=0x255, overflow=0, sig_digits=3.
REQ-028 SHALL cover: binary=0 -> bcd=0x000, overflow=0, sig_digits=1; binary=9 -> bcd=0x009, sig_digits=1.
REQ-029 SHALL cover: DIGITS=2, binary=200 -> bcd=0x00, overflow=1, sig_digits=1; binary=99 -> bcd=0x99, overflow=0.
REQ-030 SHALL cover: start pulsed with binary=42 during SHIFT of binary=17 -> single done, bcd=0x017.
REQ-031 SHALL cover: rst_n low at cycle 4 of conversion -> no done, all outputs reset; new start of 128 -> bcd=0x128.
REQ-032 SHALL cover: start held high continuously, BIN_W=16, DIGITS=5, 65535 then 10000 -> done every 17 cycles, bcd=0x65535 then 0x10000.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, MSB first.
// Produces packed BCD, a sticky overflow flag and the count of significant digits.
module bcd_converter_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              binary,
    output logic                          busy,
    output logic                          done,
    output logic [4*DIGITS-1:0]           bcd,
    output logic                          overflow,
    output logic [$clog2(DIGITS+1)-1:0]   sig_digits
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SIG_W = $clog2(DIGITS + 1);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   next_work;
    logic               carry;
    logic               carry_out;
    logic [CNT_W-1:0]   cnt;

    // Index of the highest nonzero digit plus one; an all-zero value still reports one digit.
    function automatic logic [SIG_W-1:0] count_sig(input logic [BCD_W-1:0] v);
        logic [SIG_W-1:0] s;
        s = SIG_W'(1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] != 4'd0) begin
                s = SIG_W'(i + 1);
            end
        end
        return s;
    endfunction

    // Add-3 correction on every digit >= 5 ahead of the shift.
    always_comb begin
        adj = work;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is the only evidence the value exceeded 10^DIGITS.
    assign carry_out = adj[BCD_W-1];
    generate
        if (BCD_W > 1) begin : g_shift_wide
            assign next_work = {adj[BCD_W-2:0], shreg[BIN_W-1]};
        end else begin : g_shift_narrow
            assign next_work = shreg[BIN_W-1];
        end
    endgenerate

    // Control FSM and datapath registers; result registers update only on the final shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            work       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
            sig_digits <= SIG_W'(1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= binary;
                        work  <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= next_work;
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    carry <= carry | carry_out;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_SHIFT) begin
                        bcd        <= next_work;
                        overflow   <= carry | carry_out;
                        sig_digits <= count_sig(next_work);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: 8-bit/3-digit, 8-bit/2-digit and 16-bit/5-digit instances.
module tb_bcd_converter_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  binary8 = '0;
    logic        start16 = 1'b0;
    logic [15:0] binary16 = '0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [1:0]  sig_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  sig_b;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;
    logic [2:0]  sig_c;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_converter_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start8), .binary(binary8),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .sig_digits(sig_a));

    bcd_converter_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start8), .binary(binary8),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .sig_digits(sig_b));

    bcd_converter_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start16), .binary(binary16),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .sig_digits(sig_c));

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd3;
        logic        ovf3;
        logic [1:0]  sig3;
        logic [7:0]  bcd2;
        logic        ovf2;
        logic [1:0]  sig2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; start is held across exactly one rising edge.
    task automatic pulse8(input logic [7:0] bin);
        binary8 = bin;
        start8  = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Counts edges after the accepting edge until done_a; a missing done is a failed check.
    task automatic wait_done8(output int lat, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = busy_a ? 1 : 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_a) seen = 1'b1;
            else if (busy_a) busy_cnt++;
        end
        check("done8_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_done16(output int c);
        bit seen;
        seen = 1'b0;
        c    = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done_c) begin
                seen = 1'b1;
                c    = cyc;
            end
        end
        check("done16_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int lat, bc, ndone, c0, c1, c2, c3;
        logic [11:0] got;

        vecs[0] = '{8'd255, 12'h255, 1'b0, 2'd3, 8'h55, 1'b1, 2'd2};
        vecs[1] = '{8'd0,   12'h000, 1'b0, 2'd1, 8'h00, 1'b0, 2'd1};
        vecs[2] = '{8'd9,   12'h009, 1'b0, 2'd1, 8'h09, 1'b0, 2'd1};
        vecs[3] = '{8'd200, 12'h200, 1'b0, 2'd3, 8'h00, 1'b1, 2'd1};
        vecs[4] = '{8'd99,  12'h099, 1'b0, 2'd2, 8'h99, 1'b0, 2'd2};
        vecs[5] = '{8'd128, 12'h128, 1'b0, 2'd3, 8'h28, 1'b1, 2'd2};
        vecs[6] = '{8'd100, 12'h100, 1'b0, 2'd3, 8'h00, 1'b1, 2'd1};
        vecs[7] = '{8'd10,  12'h010, 1'b0, 2'd2, 8'h10, 1'b0, 2'd2};

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_bcd", 32'(bcd_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_sig", 32'(sig_a), 32'd1);
        check("rst_sig16", 32'(sig_c), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulse8(vecs[i].bin);
            wait_done8(lat, bc);
            check("latency", 32'(lat), 32'd8);
            check("busy_cycles", 32'(bc), 32'd8);
            check("busy_in_done", 32'(busy_a), 32'd0);
            check("bcd3", 32'(bcd_a), 32'(vecs[i].bcd3));
            check("ovf3", 32'(ovf_a), 32'(vecs[i].ovf3));
            check("sig3", 32'(sig_a), 32'(vecs[i].sig3));
            check("done2", 32'(done_b), 32'd1);
            check("bcd2", 32'(bcd_b), 32'(vecs[i].bcd2));
            check("ovf2", 32'(ovf_b), 32'(vecs[i].ovf2));
            check("sig2", 32'(sig_b), 32'(vecs[i].sig2));
            @(posedge clk);
            #1;
            check("done_pulse_end", 32'(done_a), 32'd0);
            check("bcd3_held", 32'(bcd_a), 32'(vecs[i].bcd3));
        end

        // Start with another value during SHIFT must be ignored
        @(negedge clk);
        pulse8(8'd17);
        repeat (3) @(posedge clk);
        @(negedge clk);
        binary8 = 8'd42;
        start8  = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        got   = '0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                ndone++;
                got = bcd_a;
            end
        end
        check("ignore_start_ndone", 32'(ndone), 32'd1);
        check("ignore_start_bcd", 32'(got), 32'h017);

        // Reset in the middle of a conversion, then start on the first edge after release
        @(negedge clk);
        pulse8(8'd200);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_bcd", 32'(bcd_a), 32'd0);
        check("midrst_ovf", 32'(ovf_a), 32'd0);
        check("midrst_sig", 32'(sig_a), 32'd1);
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse8(8'd128);
        wait_done8(lat, bc);
        check("postrst_latency", 32'(lat), 32'd8);
        check("postrst_bcd3", 32'(bcd_a), 32'h128);
        check("postrst_bcd2", 32'(bcd_b), 32'h28);
        check("postrst_ovf2", 32'(ovf_b), 32'd1);

        // Start held high: back-to-back conversions every BIN_W+1 cycles
        @(negedge clk);
        c0       = cyc;
        binary16 = 16'd65535;
        start16  = 1'b1;
        wait_done16(c1);
        check("b2b_first_lat", 32'(c1 - c0), 32'd17);
        check("b2b_bcd0", 32'(bcd_c), 32'h65535);
        check("b2b_sig0", 32'(sig_c), 32'd5);
        check("b2b_ovf0", 32'(ovf_c), 32'd0);
        binary16 = 16'd10000;
        wait_done16(c2);
        check("b2b_period1", 32'(c2 - c1), 32'd17);
        check("b2b_bcd1", 32'(bcd_c), 32'h10000);
        check("b2b_sig1", 32'(sig_c), 32'd5);
        wait_done16(c3);
        check("b2b_period2", 32'(c3 - c2), 32'd17);
        check("b2b_bcd2", 32'(bcd_c), 32'h10000);
        start16 = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
